// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM read port between up to four pixel requesters,
// returning tagged read data after a fixed latency in grant order.

module sprite_rom_arbiter_chk #(
   parameter int N_REQ = 4
) (
   input logic             clk,
   input logic             rstn,
   input logic [N_REQ-1:0] gnt,
   input logic             rom_en,
   input logic             rd_valid,
   input logic             busy
);

   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));

   a_en_matches_gnt : assert property (@(posedge clk) disable iff (!rstn) rom_en == (|gnt));

   a_no_back_to_back : assert property (@(posedge clk) disable iff (!rstn)
      (gnt & $past(gnt)) == {N_REQ{1'b0}});

   a_rd_implies_busy : assert property (@(posedge clk) disable iff (!rstn) rd_valid |-> busy);

endmodule

module sprite_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 12,
   parameter int ROM_LAT = 2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] addr_in,
   input  logic                    prio_mode,
   input  logic                    stall,
   output logic [N_REQ-1:0]        gnt,
   output logic                    rom_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_dout,
   output logic                    rd_valid,
   output logic [1:0]              rd_id,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    busy
);

   logic [N_REQ-1:0]         gnt_r;
   logic                     rom_en_r;
   logic [ADDR_W-1:0]        rom_addr_r;
   logic [1:0]               ptr_r;
   logic [1:0]               gnt_idx_r;
   logic [ROM_LAT-1:0]       pipe_v_r;
   logic [ROM_LAT-1:0][1:0]  pipe_id_r;
   logic                     rd_valid_r;
   logic [1:0]               rd_id_r;
   logic [DATA_W-1:0]        rd_data_r;
   logic                     busy_r;

   logic [N_REQ-1:0]         elig_s;
   logic                     win_s;
   logic [1:0]               win_idx_s;
   logic                     grant_s;
   logic [N_REQ-1:0]         gnt_nxt_s;
   logic [ADDR_W-1:0]        addr_sel_s;
   logic                     busy_nxt_s;

   // The current holder is masked so a one-cycle-late req drop is not granted twice.
   assign elig_s  = req & ~gnt_r;
   assign grant_s = win_s & ~stall;

   // Winner selection: lowest index in fixed mode, first after ptr in round-robin.
   always_comb begin : arb_comb
      int   rr_idx_v;
      logic hit_v;
      win_s     = 1'b0;
      win_idx_s = 2'd0;
      rr_idx_v  = 0;
      hit_v     = 1'b0;
      if (prio_mode) begin
         for (int i = N_REQ - 1; i >= 0; i--) begin
            hit_v     = elig_s[i];
            win_idx_s = hit_v ? 2'(i) : win_idx_s;
            win_s     = win_s | hit_v;
         end
      end else begin
         // Walk offsets from farthest to nearest so the nearest hit is the one kept.
         for (int off = N_REQ; off >= 1; off--) begin
            rr_idx_v  = (int'(ptr_r) + off) % N_REQ;
            hit_v     = elig_s[rr_idx_v];
            win_idx_s = hit_v ? 2'(rr_idx_v) : win_idx_s;
            win_s     = win_s | hit_v;
         end
      end
   end

   // One-hot grant vector and winner address mux.
   always_comb begin
      gnt_nxt_s  = {N_REQ{1'b0}};
      addr_sel_s = {ADDR_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         gnt_nxt_s[i] = grant_s & (win_idx_s == 2'(i));
         addr_sel_s   = (win_idx_s == 2'(i)) ? addr_in[i*ADDR_W +: ADDR_W] : addr_sel_s;
      end
   end

   // Next-cycle busy: anything that will be a rom_en, pipeline valid or rd_valid.
   assign busy_nxt_s = grant_s | rom_en_r | (|pipe_v_r);

   // Grant, ROM request and round-robin pointer registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt_r      <= {N_REQ{1'b0}};
         rom_en_r   <= 1'b0;
         rom_addr_r <= {ADDR_W{1'b0}};
         ptr_r      <= 2'(N_REQ - 1);
         gnt_idx_r  <= 2'd0;
         busy_r     <= 1'b0;
      end else begin
         gnt_r    <= gnt_nxt_s;
         rom_en_r <= grant_s;
         busy_r   <= busy_nxt_s;
         if (grant_s) begin
            rom_addr_r <= addr_sel_s;
            ptr_r      <= win_idx_s;
            gnt_idx_r  <= win_idx_s;
         end
      end
   end

   // Return tag pipeline tracking reads through the ROM latency.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_v_r  <= {ROM_LAT{1'b0}};
         pipe_id_r <= {ROM_LAT{2'd0}};
      end else begin
         pipe_v_r[0]  <= rom_en_r;
         pipe_id_r[0] <= gnt_idx_r;
         for (int i = ROM_LAT - 1; i > 0; i--) begin
            pipe_v_r[i]  <= pipe_v_r[i-1];
            pipe_id_r[i] <= pipe_id_r[i-1];
         end
      end
   end

   // Output stage: captures ROM data alongside its requester tag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_valid_r <= 1'b0;
         rd_id_r    <= 2'd0;
         rd_data_r  <= {DATA_W{1'b0}};
      end else begin
         rd_valid_r <= pipe_v_r[ROM_LAT-1];
         rd_id_r    <= pipe_id_r[ROM_LAT-1];
         if (pipe_v_r[ROM_LAT-1]) begin
            rd_data_r <= rom_dout;
         end
      end
   end

   assign gnt      = gnt_r;
   assign rom_en   = rom_en_r;
   assign rom_addr = rom_addr_r;
   assign rd_valid = rd_valid_r;
   assign rd_id    = rd_id_r;
   assign rd_data  = rd_data_r;
   assign busy     = busy_r;

   sprite_rom_arbiter_chk #(.N_REQ(N_REQ)) u_chk (
      .clk      (clk),
      .rstn     (rstn),
      .gnt      (gnt_r),
      .rom_en   (rom_en_r),
      .rd_valid (rd_valid_r),
      .busy     (busy_r)
   );

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed self-checking bench for sprite_rom_arbiter with a two-stage ROM model.

module tb_sprite_rom_arbiter;

   localparam int N_REQ   = 4;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 12;
   localparam int ROM_LAT = 2;

   logic                    clk;
   logic                    rstn;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] addr_in;
   logic                    prio_mode;
   logic                    stall;
   logic [N_REQ-1:0]        gnt;
   logic                    rom_en;
   logic [ADDR_W-1:0]       rom_addr;
   logic [DATA_W-1:0]       rom_dout;
   logic                    rd_valid;
   logic [1:0]              rd_id;
   logic [DATA_W-1:0]       rd_data;
   logic                    busy;

   logic [DATA_W-1:0]       rom_s1;
   int n_checks = 0;
   int n_pass   = 0;

   sprite_rom_arbiter #(
      .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
   ) dut (
      .clk(clk), .rstn(rstn), .req(req), .addr_in(addr_in),
      .prio_mode(prio_mode), .stall(stall), .gnt(gnt), .rom_en(rom_en),
      .rom_addr(rom_addr), .rom_dout(rom_dout), .rd_valid(rd_valid),
      .rd_id(rd_id), .rd_data(rd_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
      return (a == 16'h0123) ? 12'hABC : (a[11:0] ^ 12'h5A5);
   endfunction

   // Synchronous ROM: address sampled at one edge, data valid after the second.
   always @(posedge clk) begin
      rom_s1   <= rom_fn(rom_addr);
      rom_dout <= rom_s1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      req       = 4'b0000;
      prio_mode = 1'b0;
      stall     = 1'b0;
      repeat (2) step();
      rstn = 1'b1;
   endtask

   initial begin
      int exp_k;
      int pulses;
      addr_in = {(N_REQ*ADDR_W){1'b0}};
      do_reset();

      // Reset values
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_rom_en", 32'(rom_en), 32'h0);
      check("rst_rom_addr", 32'(rom_addr), 32'h0);
      check("rst_rd_valid", 32'(rd_valid), 32'h0);
      check("rst_rd_id", 32'(rd_id), 32'h0);
      check("rst_rd_data", 32'(rd_data), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);

      // Single read
      addr_in[0 +: 16] = 16'h0123;
      req = 4'b0001;
      step();
      check("single_gnt", 32'(gnt), 32'h1);
      check("single_rom_en", 32'(rom_en), 32'h1);
      check("single_addr", 32'(rom_addr), 32'h0123);
      check("single_busy_c1", 32'(busy), 32'h1);
      req = 4'b0000;
      step();
      check("single_gnt_c2", 32'(gnt), 32'h0);
      step();
      check("single_rdv_c3", 32'(rd_valid), 32'h0);
      step();
      check("single_rdv_c4", 32'(rd_valid), 32'h1);
      check("single_id_c4", 32'(rd_id), 32'h0);
      check("single_data_c4", 32'(rd_data), 32'hABC);
      check("single_busy_c4", 32'(busy), 32'h1);
      step();
      check("single_rdv_c5", 32'(rd_valid), 32'h0);
      check("single_busy_c5", 32'(busy), 32'h0);
      check("single_hold_c5", 32'(rd_data), 32'hABC);

      // Round-robin with all requesters held
      do_reset();
      for (int i = 0; i < N_REQ; i++) addr_in[i*16 +: 16] = 16'h1000 + 16'(i);
      req = 4'b1111;
      for (int c = 1; c <= 10; c++) begin
         step();
         exp_k = (c - 1) % 4;
         check("rr_gnt", 32'(gnt), 32'h1 << exp_k);
         check("rr_addr", 32'(rom_addr), 32'h1000 + 32'(exp_k));
         if (c >= 4) begin
            check("rr_rdv", 32'(rd_valid), 32'h1);
            check("rr_rd_id", 32'(rd_id), 32'((c - 4) % 4));
            check("rr_rd_data", 32'(rd_data), 32'(rom_fn(16'h1000 + 16'((c - 4) % 4))));
         end
      end
      req = 4'b0000;
      repeat (6) step();
      check("rr_drained", 32'(busy), 32'h0);

      // Fixed priority, holder mask alternates 1 and 2
      do_reset();
      prio_mode = 1'b1;
      req = 4'b0110;
      for (int c = 1; c <= 8; c++) begin
         step();
         check("fix_gnt", 32'(gnt), (c % 2 == 1) ? 32'h2 : 32'h4);
      end
      req = 4'b0000;
      prio_mode = 1'b0;
      repeat (6) step();

      // Stall after two grants
      do_reset();
      req = 4'b1111;
      step();
      check("stall_g0", 32'(gnt), 32'h1);
      step();
      check("stall_g1", 32'(gnt), 32'h2);
      stall = 1'b1;
      for (int c = 3; c <= 7; c++) begin
         step();
         check("stall_no_gnt", 32'(gnt), 32'h0);
         check("stall_rdv", 32'(rd_valid), (c == 4 || c == 5) ? 32'h1 : 32'h0);
         if (c == 4 || c == 5) check("stall_rd_id", 32'(rd_id), 32'(c - 4));
      end
      stall = 1'b0;
      step();
      check("stall_resume", 32'(gnt), 32'h4);
      req = 4'b0000;
      repeat (6) step();

      // Reset while a read is in flight
      do_reset();
      addr_in[0 +: 16] = 16'h0123;
      req = 4'b0001;
      step();
      check("mid_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      step();
      rstn = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      step();
      rstn = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         pulses += int'(rd_valid);
      end
      check("mid_no_rdv", 32'(pulses), 32'h0);
      check("mid_busy_idle", 32'(busy), 32'h0);

      // Same requester holding req for four cycles
      do_reset();
      addr_in[2*16 +: 16] = 16'h2222;
      req = 4'b0100;
      pulses = 0;
      for (int c = 1; c <= 9; c++) begin
         step();
         check("hold_gnt", 32'(gnt), (c == 1 || c == 3) ? 32'h4 : 32'h0);
         if (rd_valid) begin
            pulses++;
            check("hold_rd_id", 32'(rd_id), 32'h2);
         end
         if (c == 4) req = 4'b0000;
      end
      check("hold_pulses", 32'(pulses), 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM read port between up to four pixel requesters (JOJO, mask_crazy, mask_top, mask_bottom) so that they no longer each need a private ROM. Sits between the role units and a single ROM wrapper. Each cycle it grants at most one requester, drives the ROM address, and returns the read data tagged with the requester ID after a fixed latency. Supports round-robin or fixed-priority arbitration, plus a stall input that freezes new grants.

## Interface
- N_REQ, 4: number of requesters (2..4)
- ADDR_W, 16: ROM address width
- DATA_W, 12: ROM data width (RGB444)
- ROM_LAT, 2: ROM read latency in cycles, from rom_addr sampled to rom_dout valid (1..4)

- clk  in  1  system clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  N_REQ  per-requester read request, level
- addr_in  in  N_REQ*ADDR_W  requester addresses, flattened; requester i at [i*ADDR_W +: ADDR_W]
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- stall  in  1  1 = issue no new grants
- gnt  out  N_REQ  one-hot grant pulse, registered
- rom_en  out  1  ROM read enable, registered
- rom_addr  out  ADDR_W  ROM address, registered
- rom_dout  in  DATA_W  ROM read data
- rd_valid  out  1  return-data strobe
- rd_id  out  2  index of the requester that owns rd_data
- rd_data  out  DATA_W  returned ROM word
- busy  out  1  1 while any read is in flight

## Operation
- Arbitration happens every cycle over an eligible set: eligible = req & ~gnt.
  - The current grant holder is masked out, so a requester that keeps req high for one cycle after seeing gnt is not granted twice.
  - If req is still high after that cycle, it counts as a new request.
- Round-robin (prio_mode=0):
  - Search starts at index ptr+1 mod N_REQ, where ptr is the last granted index.
  - ptr updates only when a grant is issued.
  - Reset value of ptr is N_REQ-1, so requester 0 wins first.
- Fixed priority (prio_mode=1): the lowest eligible index wins. ptr keeps updating on each grant.
- prio_mode changes take effect at the next arbitration.
- On a win by requester k (eligible non-empty and stall=0), on the next edge:
  - gnt = 1<<k
  - rom_en = 1
  - rom_addr = addr_in[k] as sampled at that edge
- Otherwise gnt=0 and rom_en=0; rom_addr holds its last value.
- The return pipeline is a shift register of {valid, id}, depth ROM_LAT+1, fed from {rom_en, k}.
  - At its output edge: rd_valid = valid, rd_id = id, rd_data = rom_dout.
  - rd_data holds its value when rd_valid=0.
- busy = OR of rom_en and all pipeline valid bits.
- stall=1 blocks new grants only. In-flight reads complete normally, and ptr is unchanged.
- N_REQ<4: unused gnt bits stay 0. rd_id uses the low bits.

## Timing
- Reset values: gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_id=0, rd_data=0, busy=0, ptr=N_REQ-1, pipeline cleared.
- Asserting rstn=0 mid-operation discards all in-flight reads immediately. No rd_valid appears until a new grant is issued after release.
- Latency:
  - gnt goes high in the cycle after req is sampled at an edge.
  - rd_valid goes high exactly ROM_LAT+1 cycles after the gnt cycle.
  - Total from req to rd_valid is ROM_LAT+2 cycles (4 by default).
- Throughput: one grant per cycle across requesters. A single requester holding req constantly is granted at most every other cycle.
- Return order equals grant order. rd_valid is a one-cycle pulse per grant.
- No request is dropped: req held with stall=0 is granted within N_REQ cycles in round-robin mode.
- Fixed mode may starve high indices by design.

## Test plan
- Single read, ROM_LAT=2:
  - Stimulus: req=0001, addr_in[0]=0x0123, ROM returns 0xABC.
  - Required: gnt=0001 and rom_addr=0x0123 in cycle 1; rd_valid=1, rd_id=0, rd_data=0xABC in cycle 4; busy low from cycle 5.
- Round-robin:
  - Stimulus: req=1111 held continuously from reset.
  - Required: grants 0,1,2,3,0,1,… one per cycle; rd_id follows the same sequence 3 cycles later.
- Fixed priority:
  - Stimulus: prio_mode=1, req=0110 held.
  - Required: grants alternate 1,2,1,2 because of the holder mask; requester 3 is never granted.
- Stall:
  - Stimulus: two grants issued, then stall=1 for 5 cycles with req=1111.
  - Required: both pending rd_valid pulses still appear; no gnt during the stall; arbitration resumes at ptr+1.
- Reset mid-flight:
  - Stimulus: rstn=0 one cycle after a grant.
  - Required: all outputs at reset values immediately; no rd_valid after release until a new request is granted.
- Same-requester hold:
  - Stimulus: req[2] held high for 4 cycles, no other requests.
  - Required: gnt[2] pulses in cycles 1 and 3 only; exactly 2 rd_valid pulses returned.
